riscv_mem_arbiter: RTL and testbench
====================================

// Module: riscv_mem_arbiter
// PURPOSE
//  Shares one single-port unified memory between instruction fetch (IF) and data access (MEM).
//  Sits between the fetch/memory stages and the memory macro.
//  Grants one requester at a time and allows one outstanding read.
//  Routes the read response back to its owner.
//  Data has priority; a starvation limit guarantees fetch progress; a watchdog bounds lost responses.
// PARAMETERS
//  WIDTH       32  data/address width
//  STARVE_MAX  4   consecutive data grants, with fetch pending, before fetch is forced
//  TIMEOUT     16  max cycles in WAIT_RESP before forced error response (>=2)
// PORTS
//  clk_in         in   1      clock, rising edge
//  rst_in         in   1      asynchronous reset, active-low
//  if_req_in      in   1      fetch read request; held with if_addr_in until if_gnt_out
//  if_addr_in     in   WIDTH  fetch byte address
//  if_gnt_out     out  1      fetch request accepted this cycle
//  if_rvalid_out  out  1      fetch read data valid (1-cycle pulse)
//  if_rdata_out   out  WIDTH  fetch read data
//  d_req_in       in   1      data request; held with d_we/addr/wdata until d_gnt_out
//  d_we_in        in   1      1=write, 0=read
//  d_addr_in      in   WIDTH  data byte address
//  d_wdata_in     in   WIDTH  write data
//  d_gnt_out      out  1      data request accepted this cycle
//  d_rvalid_out   out  1      data read valid (1-cycle pulse)
//  d_rdata_out    out  WIDTH  data read data
//  mem_req_out    out  1      memory access strobe
//  mem_we_out     out  1      memory write enable
//  mem_addr_out   out  WIDTH  memory address
//  mem_wdata_out  out  WIDTH  memory write data
//  mem_rvalid_in  in   1      memory read response valid
//  mem_rdata_in   in   WIDTH  memory read data
//  err_out        out  1      1-cycle pulse on watchdog timeout
// BEHAVIOUR
//  Reset: state=IDLE, owner=IF, starve_cnt=0, wd_cnt=0.
//   All gnt/rvalid/mem_req/mem_we/err outputs=0; rdata outputs=0.
//  States: IDLE, WAIT_RESP.
//  IDLE, grant decision (combinational, same cycle as request):
//   d_req & ~(if_req & starve_cnt==STARVE_MAX) -> grant data; else if_req -> grant fetch.
//  On grant: mem_req_out=1; mem_we/addr/wdata driven from the winner (mem_we=0 for fetch).
//  Write grant: completes in the grant cycle; no rvalid; state stays IDLE (back-to-back writes allowed).
//  Read grant: owner latched; wd_cnt<=0; next state WAIT_RESP.
//  WAIT_RESP: no grants (gnt=0, mem_req=0); wd_cnt increments each cycle.
//   mem_rvalid_in=1 -> owner rvalid=1 and rdata=mem_rdata_in (combinational), same cycle; next state IDLE.
//   wd_cnt==TIMEOUT-1 without rvalid -> owner rvalid=1, rdata=0, err_out=1; next state IDLE.
//   rvalid and timeout in the same cycle -> real data wins, err_out=0.
//  Minimum read cadence: 2 cycles (grant, response); next grant earliest in the cycle after the response.
//  mem_rvalid_in while IDLE: ignored (no rvalid output, no error).
//  starve_cnt: +1 on each data grant while if_req_in=1; saturates at STARVE_MAX.
//   Cleared on fetch grant, and when if_req_in=0 in IDLE.
//  Non-owner rvalid is always 0; non-owner rdata is held at 0.
//  Reset asserted mid-WAIT_RESP: aborts immediately to reset values; the late response is ignored.
// TESTING
//  1. Fetch read 0x100, memory responds 1 cycle later with 0xDEADBEEF
//     -> if_gnt cycle 0, if_rvalid with 0xDEADBEEF cycle 1.
//  2. if_req and d_req (read 0x200) both high in IDLE
//     -> d_gnt=1, if_gnt=0; fetch is granted in the cycle after the data response.
//  3. Fetch held high with 5 back-to-back data writes (STARVE_MAX=4)
//     -> 4 writes granted, 5th cycle if_gnt=1 and d_gnt=0.
//  4. Data read with no mem_rvalid_in
//     -> at cycle TIMEOUT after grant, d_rvalid=1, d_rdata=0, err_out=1; IDLE next cycle.
//  5. rst_in low while in WAIT_RESP, then mem_rvalid_in pulses after release
//     -> all outputs 0, no rvalid, no err_out.
//  6. mem_rvalid_in on the exact timeout cycle
//     -> rvalid carries mem_rdata_in, err_out=0.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data has priority, fetch is forced after STARVE_MAX data grants, and one read is in flight at most.
module riscv_mem_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             if_req_in,
    input  logic [WIDTH-1:0] if_addr_in,
    output logic             if_gnt_out,
    output logic             if_rvalid_out,
    output logic [WIDTH-1:0] if_rdata_out,
    input  logic             d_req_in,
    input  logic             d_we_in,
    input  logic [WIDTH-1:0] d_addr_in,
    input  logic [WIDTH-1:0] d_wdata_in,
    output logic             d_gnt_out,
    output logic             d_rvalid_out,
    output logic [WIDTH-1:0] d_rdata_out,
    output logic             mem_req_out,
    output logic             mem_we_out,
    output logic [WIDTH-1:0] mem_addr_out,
    output logic [WIDTH-1:0] mem_wdata_out,
    input  logic             mem_rvalid_in,
    input  logic [WIDTH-1:0] mem_rdata_in,
    output logic             err_out
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned WW = $clog2(TIMEOUT);

    typedef enum logic [0:0] {StIdle, StWaitResp} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;  // 1 = data, 0 = fetch
    logic [SW-1:0]   starve_q, starve_d;
    logic [WW-1:0]   wd_q, wd_d;

    logic             fetch_forced;
    logic             grant_d;
    logic             grant_if;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            starve_q <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        starve_d      = starve_q;
        wd_d          = wd_q;
        if_gnt_out    = 1'b0;
        d_gnt_out     = 1'b0;
        mem_req_out   = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        err_out       = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;

        fetch_forced = if_req_in && (starve_q == SW'(STARVE_MAX));
        // Grants are combinational from the requests, so keep them quiet while reset is held.
        grant_d      = rst_in && d_req_in && !fetch_forced;
        grant_if     = rst_in && if_req_in && !grant_d;

        unique case (state_q)
            StIdle: begin
                if (!if_req_in) begin
                    starve_d = '0;
                end
                if (grant_d) begin
                    d_gnt_out     = 1'b1;
                    mem_req_out   = 1'b1;
                    mem_we_out    = d_we_in;
                    mem_addr_out  = d_addr_in;
                    mem_wdata_out = d_wdata_in;
                    if (if_req_in && (starve_q != SW'(STARVE_MAX))) begin
                        starve_d = starve_q + SW'(1);
                    end
                    if (!d_we_in) begin
                        owner_d = 1'b1;
                        wd_d    = '0;
                        state_d = StWaitResp;
                    end
                end else if (grant_if) begin
                    if_gnt_out   = 1'b1;
                    mem_req_out  = 1'b1;
                    mem_addr_out = if_addr_in;
                    starve_d     = '0;
                    owner_d      = 1'b0;
                    wd_d         = '0;
                    state_d      = StWaitResp;
                end
            end
            StWaitResp: begin
                wd_d = wd_q + WW'(1);
                if (mem_rvalid_in) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem_rdata_in;
                    state_d   = StIdle;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    rsp_valid = 1'b1;
                    err_out   = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Response is steered to the latched owner; the other side stays at zero.
    assign if_rvalid_out = rsp_valid && !owner_q;
    assign d_rvalid_out  = rsp_valid && owner_q;
    assign if_rdata_out  = owner_q ? '0 : rsp_data;
    assign d_rdata_out   = owner_q ? rsp_data : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: per-cycle vector table plus a response scoreboard.
module tb_riscv_mem_arbiter;

    localparam int W    = 32;
    localparam int SMAX = 4;
    localparam int TO   = 16;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          if_req_in = 1'b0;
    logic [W-1:0]  if_addr_in = '0;
    logic          if_gnt_out, if_rvalid_out;
    logic [W-1:0]  if_rdata_out;
    logic          d_req_in = 1'b0, d_we_in = 1'b0;
    logic [W-1:0]  d_addr_in = '0, d_wdata_in = '0;
    logic          d_gnt_out, d_rvalid_out;
    logic [W-1:0]  d_rdata_out;
    logic          mem_req_out, mem_we_out;
    logic [W-1:0]  mem_addr_out, mem_wdata_out;
    logic          mem_rvalid_in = 1'b0;
    logic [W-1:0]  mem_rdata_in = '0;
    logic          err_out;

    riscv_mem_arbiter #(.WIDTH(W), .STARVE_MAX(SMAX), .TIMEOUT(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_gnt_out(if_gnt_out),
        .if_rvalid_out(if_rvalid_out), .if_rdata_out(if_rdata_out),
        .d_req_in(d_req_in), .d_we_in(d_we_in), .d_addr_in(d_addr_in),
        .d_wdata_in(d_wdata_in), .d_gnt_out(d_gnt_out), .d_rvalid_out(d_rvalid_out),
        .d_rdata_out(d_rdata_out), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
        .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in), .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic ifr; logic [W-1:0] ia;
        logic dr; logic dwe; logic [W-1:0] da; logic [W-1:0] dwd;
        logic mrv; logic [W-1:0] mrd;
        logic eig; logic edg; logic eirv; logic edrv; logic eerr;
        logic to;  // read granted here is expected to end in a watchdog error
    } vec_t;

    typedef struct {
        logic         own;  // 1 = data
        logic [W-1:0] data;
        logic         err;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [W-1:0] mem_model(input logic [W-1:0] addr);
        if (addr == 32'h100) return 32'hDEAD_BEEF;
        return {addr[15:0], ~addr[15:0]};
    endfunction

    function automatic vec_t mk(input logic ifr, input logic [W-1:0] ia, input logic dr,
                                input logic dwe, input logic [W-1:0] da, input logic [W-1:0] dwd,
                                input logic mrv, input logic [W-1:0] mrd, input logic eig,
                                input logic edg, input logic eirv, input logic edrv,
                                input logic eerr, input logic to);
        vec_t v;
        v.ifr = ifr; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.mrv = mrv; v.mrd = mrd; v.eig = eig; v.edg = edg; v.eirv = eirv;
        v.edrv = edrv; v.eerr = eerr; v.to = to;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        if_req_in = v.ifr; if_addr_in = v.ia;
        d_req_in = v.dr; d_we_in = v.dwe; d_addr_in = v.da; d_wdata_in = v.dwd;
        mem_rvalid_in = v.mrv; mem_rdata_in = v.mrd;
    endtask

    task automatic sb_sample(input string name);
        sb_t e;
        if (if_rvalid_out || d_rvalid_out) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s unexpected rvalid if=%0b d=%0b expected none", name,
                         if_rvalid_out, d_rvalid_out);
            end else begin
                e = sb_q.pop_front();
                chk({name, " rsp owner"}, {31'b0, d_rvalid_out}, {31'b0, e.own});
                chk({name, " rsp single"}, {31'b0, if_rvalid_out & d_rvalid_out}, '0);
                chk({name, " rsp data"}, e.own ? d_rdata_out : if_rdata_out, e.data);
                chk({name, " rsp other rdata"}, e.own ? if_rdata_out : d_rdata_out, '0);
                chk({name, " rsp err"}, {31'b0, err_out}, {31'b0, e.err});
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        sb_t e;
        @(posedge clk_in);
        #1;
        apply(v);
        if (v.eig || (v.edg && !v.dwe)) begin
            e.own  = v.edg;
            e.data = v.to ? '0 : mem_model(v.edg ? v.da : v.ia);
            e.err  = v.to;
            sb_q.push_back(e);
        end
        @(negedge clk_in);
        chk({name, " if_gnt"}, {31'b0, if_gnt_out}, {31'b0, v.eig});
        chk({name, " d_gnt"}, {31'b0, d_gnt_out}, {31'b0, v.edg});
        chk({name, " if_rvalid"}, {31'b0, if_rvalid_out}, {31'b0, v.eirv});
        chk({name, " d_rvalid"}, {31'b0, d_rvalid_out}, {31'b0, v.edrv});
        chk({name, " err"}, {31'b0, err_out}, {31'b0, v.eerr});
        chk({name, " mem_req"}, {31'b0, mem_req_out}, {31'b0, v.eig | v.edg});
        if (v.eig || v.edg) begin
            chk({name, " mem_we"}, {31'b0, mem_we_out}, {31'b0, v.edg & v.dwe});
            chk({name, " mem_addr"}, mem_addr_out, v.edg ? v.da : v.ia);
            if (v.edg && v.dwe) chk({name, " mem_wdata"}, mem_wdata_out, v.dwd);
        end
        sb_sample(name);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " if_gnt"}, {31'b0, if_gnt_out}, '0);
        chk({name, " d_gnt"}, {31'b0, d_gnt_out}, '0);
        chk({name, " if_rvalid"}, {31'b0, if_rvalid_out}, '0);
        chk({name, " d_rvalid"}, {31'b0, d_rvalid_out}, '0);
        chk({name, " if_rdata"}, if_rdata_out, '0);
        chk({name, " d_rdata"}, d_rdata_out, '0);
        chk({name, " mem_req"}, {31'b0, mem_req_out}, '0);
        chk({name, " mem_we"}, {31'b0, mem_we_out}, '0);
        chk({name, " err"}, {31'b0, err_out}, '0);
    endtask

    initial begin
        // Reset with requests and a stray response driven: everything must stay quiet.
        #1 rst_in = 1'b0;
        if_req_in = 1'b1; d_req_in = 1'b1; mem_rvalid_in = 1'b1; mem_rdata_in = 32'h1111_2222;
        repeat (2) @(negedge clk_in);
        chk_all_zero("reset");
        @(posedge clk_in);
        #1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_in = 1'b1;

        // Fetch read, response next cycle.
        tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0));
        // Both request: data wins, fetch follows the data response.
        tbl.push_back(mk(1, 32'h104, 1, 0, 32'h200, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h104, 0, 0, 0, 0, 1, mem_model(32'h200), 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h104, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, mem_model(32'h104), 0, 0, 1, 0, 0, 0));
        // Starvation: four writes, then fetch is forced.
        for (int i = 0; i < SMAX; i++) begin
            tbl.push_back(mk(1, 32'h108, 1, 1, 32'h300 + 4 * i, 32'h1000 + i, 0, 0,
                             0, 1, 0, 0, 0, 0));
        end
        tbl.push_back(mk(1, 32'h108, 1, 1, 32'h310, 32'h1004, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h310, 32'h1004, 1, mem_model(32'h108), 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h310, 32'h1004, 0, 0, 0, 1, 0, 0, 0, 0));
        // Stray response while idle is ignored.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Data read with no response: watchdog fires at cycle TIMEOUT.
        run_vec(mk(1, 32'h500, 1, 0, 32'h400, 0, 0, 0, 0, 1, 0, 0, 0, 1), "to grant");
        for (int k = 1; k < TO; k++) begin
            run_vec(mk(1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("to wait%0d", k));
        end
        run_vec(mk(1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "to fire");
        run_vec(mk(1, 32'h500, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "to next grant");
        run_vec(mk(0, 0, 0, 0, 0, 0, 1, mem_model(32'h500), 0, 0, 1, 0, 0, 0), "to next rsp");

        // Real response on the timeout cycle wins over the watchdog.
        run_vec(mk(0, 0, 1, 0, 32'h600, 0, 0, 0, 0, 1, 0, 0, 0, 0), "edge grant");
        for (int k = 1; k < TO; k++) begin
            run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("edge wait%0d", k));
        end
        run_vec(mk(0, 0, 0, 0, 0, 0, 1, mem_model(32'h600), 0, 0, 0, 1, 0, 0), "edge rsp");

        // Reset in the middle of a read; the late response must be ignored.
        run_vec(mk(0, 0, 1, 0, 32'h700, 0, 0, 0, 0, 1, 0, 0, 0, 0), "rst grant");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst wait");
        @(posedge clk_in);
        #1;
        apply(mk(1, 32'h900, 1, 0, 32'h700, 0, 1, mem_model(32'h700), 0, 0, 0, 0, 0, 0));
        rst_in = 1'b0;
        #1;
        chk_all_zero("rst async");
        @(negedge clk_in);
        chk_all_zero("rst held");
        sb_q.delete();  // the aborted read never returns
        @(posedge clk_in);
        #1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_in = 1'b1;
        run_vec(mk(0, 0, 0, 0, 0, 0, 1, mem_model(32'h700), 0, 0, 0, 0, 0, 0), "rst late rsp");
        run_vec(mk(1, 32'h800, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "rst recover grant");
        run_vec(mk(0, 0, 0, 0, 0, 0, 1, mem_model(32'h800), 0, 0, 1, 0, 0, 0), "rst recover rsp");

        chk("scoreboard drained", sb_q.size(), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
